// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states,
// lane-select patterns and load-extension masks.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    localparam logic [3:0]        BSEL_BYTE = 4'b0001;
    localparam logic [3:0]        BSEL_HALF = 4'b0011;
    localparam logic [3:0]        BSEL_WORD = 4'b1111;
    localparam logic [WORD_W-1:0] MASK_BYTE = 32'h0000_00ff;
    localparam logic [WORD_W-1:0] MASK_HALF = 32'h0000_ffff;
    localparam logic [WORD_W-1:0] MASK_WORD = 32'hffff_ffff;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_ILL) ||
               ((size == SZ_HALF) && off[0]) ||
               ((size == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering for one access: byte enables, store-data shift, load extract/extend, misalign flag.
// Purely combinational, zero latency; no flow control of its own.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WORD_W-1:0] rdata_raw,
    output logic [3:0]        byte_sel,
    output logic [WORD_W-1:0] wdata_sh,
    output logic [WORD_W-1:0] rdata_ext,
    output logic              misalign
);

    logic [4:0]        shamt;
    logic [WORD_W-1:0] wmask;
    logic [WORD_W-1:0] rsh;

    always_comb begin
        shamt     = {addr_lo, 3'b000};
        misalign  = is_misaligned(size, addr_lo);
        rsh       = rdata_raw >> shamt;
        byte_sel  = 4'b0000;
        wmask     = '0;
        rdata_ext = '0;
        case (size)
            SZ_BYTE: begin
                byte_sel  = BSEL_BYTE << addr_lo;
                wmask     = MASK_BYTE;
                rdata_ext = is_unsigned ? {24'h0, rsh[7:0]} : {{24{rsh[7]}}, rsh[7:0]};
            end
            SZ_HALF: begin
                byte_sel  = BSEL_HALF << addr_lo;
                wmask     = MASK_HALF;
                rdata_ext = is_unsigned ? {16'h0, rsh[15:0]} : {{16{rsh[15]}}, rsh[15:0]};
            end
            SZ_WORD: begin
                byte_sel  = BSEL_WORD;
                wmask     = MASK_WORD;
                rdata_ext = rsh;
            end
            default: ;
        endcase
        // An illegal access must never touch memory nor return stale bytes.
        if (misalign) begin
            byte_sel  = 4'b0000;
            rdata_ext = '0;
        end
        wdata_sh = (wdata & wmask) << shamt;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (DMEM_ARB_ROUND_ROBIN_EN selects round-robin, else port 0 priority).
// Latency: gnt one cycle after req is seen in IDLE, rvalid one cycle later; one access per 3 cycles.
// Backpressure: requesters hold req and fields until gnt; requests during ACCESS/RESP wait for IDLE.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_size,
    input  logic              p0_unsigned,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_size,
    input  logic              p1_unsigned,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,

    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [3:0]        mem_byte_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              any_req;
    logic              win;
    logic              in_access;

    logic [3:0]        la_byte_sel;
    logic [DATA_W-1:0] la_wdata_sh;
    logic [DATA_W-1:0] la_rdata_ext;
    logic              la_misalign;

    assign any_req = p0_req | p1_req;

    dmem_lane_align u_lane_align (
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata_raw   (mem_read_data),
        .byte_sel    (la_byte_sel),
        .wdata_sh    (la_wdata_sh),
        .rdata_ext   (la_rdata_ext),
        .misalign    (la_misalign)
    );

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;

    always_comb begin
        win   = (p0_req && p1_req) ? ptr_q : !p0_req;
        ptr_d = ptr_q;
        if ((state_q == ST_IDLE) && any_req) begin
            ptr_d = !win;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        win = !p0_req;
    end
`endif

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        uns_d    = uns_q;
        gnt_d    = 2'b00;
        rvalid_d = 2'b00;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d    = ST_ACCESS;
                    sel_d      = win;
                    we_d       = win ? p1_we       : p0_we;
                    addr_d     = win ? p1_addr     : p0_addr;
                    wdata_d    = win ? p1_wdata    : p0_wdata;
                    size_d     = win ? p1_size     : p0_size;
                    uns_d      = win ? p1_unsigned : p0_unsigned;
                    gnt_d[win] = 1'b1;
                end
            end
            ST_ACCESS: begin
                state_d         = ST_RESP;
                rvalid_d[sel_q] = 1'b1;
                rdata_d         = (we_q || la_misalign) ? '0 : la_rdata_ext;
                err_d           = la_misalign;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Reset gates the strobes directly so an aborted store never commits at the reset edge.
    assign in_access        = (state_q == ST_ACCESS) && !reset && !la_misalign;
    assign mem_read_enable  = in_access && !we_q;
    assign mem_write_enable = in_access && we_q;
    assign mem_byte_sel     = in_access ? la_byte_sel : 4'b0000;
    assign mem_write_data   = (in_access && we_q) ? la_wdata_sh : '0;
    assign mem_addr         = addr_q;

    assign p0_gnt    = gnt_q[0];
    assign p1_gnt    = gnt_q[1];
    assign p0_rvalid = rvalid_q[0];
    assign p1_rvalid = rvalid_q[1];
    assign p0_rdata  = rvalid_q[0] ? rdata_q : '0;
    assign p1_rdata  = rvalid_q[1] ? rdata_q : '0;
    assign p0_err    = rvalid_q[0] & err_q;
    assign p1_err    = rvalid_q[1] & err_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width of both ports and the memory side.
REQ-002 Parameter DATA_W, default 32, data word width; fixed at 32.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pN_req  input  1  (N=0,1) access request; held stable with its fields until pN_gnt.
REQ-006 pN_we  input  1  1=store, 0=load.
REQ-007 pN_addr  input  ADDR_W  byte address.
REQ-008 pN_wdata  input  32  store data, right-aligned.
REQ-009 pN_size  input  2  00=byte, 01=half, 10=word; 11 is illegal.
REQ-010 pN_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 pN_gnt  output  1  one-cycle pulse; request accepted.
REQ-012 pN_rvalid  output  1  one-cycle pulse; response for port N.
REQ-013 pN_rdata  output  32  extended load data, valid while pN_rvalid.
REQ-014 pN_err  output  1  misaligned or illegal size, valid while pN_rvalid.
REQ-015 mem_read_enable, mem_write_enable  output  1 each  memory strobes.
REQ-016 mem_byte_sel  output  4  lane k enables mem_write_data[8k+7:8k].
REQ-017 mem_addr  output  ADDR_W; mem_write_data  output  32; mem_read_data  input  32, combinational read of mem_addr.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS when any req, ACCESS->RESP always, RESP->IDLE always.
REQ-019 In IDLE the arbiter picks one requesting port and latches its fields; the chosen pN_gnt pulses in the following (ACCESS) cycle.
REQ-020 In ACCESS the memory outputs are driven from the latched fields for exactly one cycle; a store commits at the closing edge and load data is captured at the same edge.
REQ-021 In RESP pN_rvalid pulses for the granted port; each access costs 3 cycles: req seen cycle N, gnt N+1, rvalid N+2, next grant earliest N+4.
REQ-022 byte_sel: byte = 0001<<addr[1:0], half = 0011<<addr[1:0], word = 1111.
REQ-023 mem_write_data = wdata replicated/shifted left by 8*addr[1:0]; mem_addr = latched addr unmodified.
REQ-024 Load: shift mem_read_data right by 8*addr[1:0], keep 8/16/32 bits, extend per pN_unsigned.
REQ-025 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11: no strobe in ACCESS, gnt still pulses, err=1, rdata=0 in RESP.
REQ-026 Stores return rvalid with rdata=0, err=0.
REQ-027 Outside ACCESS all mem_* strobes are 0, byte_sel 0000.
REQ-028 Simultaneous requests in IDLE resolved per REQ-034; the loser keeps req asserted and is served next.
REQ-029 Requests arriving during ACCESS/RESP are not sampled until IDLE.

Reset
REQ-030 reset forces IDLE, all gnt/rvalid/err/strobes 0, rdata 0, priority pointer to port 0.
REQ-031 reset asserted during ACCESS suppresses the store at that edge; no rvalid is issued for the aborted access.

Configuration
REQ-032 Macro DMEM_ARB_ROUND_ROBIN_EN selects arbitration policy.
REQ-033 Without it: fixed priority, port 0 always wins contention.
REQ-034 With it: round-robin; pointer moves to the non-granted port after each grant; on contention the pointed port wins.

Structure
REQ-035 Shared package dmem_pkg holds size encodings, FSM state enum and lane-select/extension constants.
REQ-036 One sub-module dmem_lane_align: combinational byte_sel generation, write shift, load extract/extend, misalign detect.

Verification
REQ-037 Port0 store word 0xDEADBEEF @0x20000000, then load word -> mem_byte_sel=1111, rdata=0xDEADBEEF, gnt at +1, rvalid at +2.
REQ-038 Port1 store byte 0x80 @addr[1:0]=2, load byte signed -> byte_sel=0100, rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-039 Port0 load half @addr ending 01 -> err=1, rdata=0, no mem strobe in any cycle.
REQ-040 Both ports req same cycle, 4 back-to-back each: fixed build grants all port0 first; round-robin build alternates 0,1,0,1.
REQ-041 reset high in ACCESS of a store of 0x12345678 -> memory word unchanged, no rvalid, FSM IDLE next cycle.
